// File: rtl/ysyx_22041071_ifu_pkg.sv
// Shared widths, default reset PC and fetch FSM encodings for the ysyx_22041071 IFU.
package ysyx_22041071_ifu_pkg;

    localparam int ADDR_BUS = 64;
    localparam int INS_BUS  = 32;
    localparam int ENTRY_W  = ADDR_BUS + INS_BUS;

    localparam logic [ADDR_BUS-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_BUS-1:0] align_pc(input logic [ADDR_BUS-1:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22041071_ifu_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, ins} entries with flush; flush beats push and pop.
module ysyx_22041071_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_22041071_ifu.sv
// Instruction-fetch stage: one outstanding imem request, buffered {pc, ins} to decode, redirects.
// Define YSYX_22041071_IFU_PERF_EN to add the perf_fetched / perf_flushed counters.
module ysyx_22041071_ifu
    import ysyx_22041071_ifu_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_ex,
    input  logic [ADDR_BUS-1:0] redirect_ex_pc,
    input  logic                redirect_id,
    input  logic [ADDR_BUS-1:0] redirect_id_pc,
    output logic                imem_req,
    output logic [ADDR_BUS-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INS_BUS-1:0]  imem_rdata,
    output logic [ADDR_BUS-1:0] PC2,
    output logic [INS_BUS-1:0]  Ins1,
    output logic                valid2,
    input  logic                ready2
`ifdef YSYX_22041071_IFU_PERF_EN
    ,
    output logic [63:0]         perf_fetched,
    output logic [63:0]         perf_flushed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e        state;
    logic [ADDR_BUS-1:0] fetch_pc;
    logic [ADDR_BUS-1:0] req_pc;
    logic                drop;
    logic                redirect;
    logic [ADDR_BUS-1:0] redirect_pc;
    logic                credit_free;
    logic                granted;
    logic                resp_seen;
    logic                push;
    logic                pop;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  head;

    assign redirect    = redirect_ex || redirect_id;
    assign redirect_pc = align_pc(redirect_ex ? redirect_ex_pc : redirect_id_pc);

    // A request may only go out if its response is guaranteed a buffer slot.
    assign credit_free = ((int'(fifo_count) + int'(state == WAIT)) < FIFO_DEPTH) && !fifo_full;
    assign imem_req    = (state == REQ) && credit_free;
    assign imem_addr   = fetch_pc;
    assign granted     = imem_req && imem_gnt;
    assign resp_seen   = (state == WAIT) && imem_rvalid;
    assign push        = resp_seen && !drop && !redirect;
    assign pop         = valid2 && ready2;
    assign valid2      = !fifo_empty;
    assign {PC2, Ins1} = head;

    ysyx_22041071_ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({req_pc, imem_rdata}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A redirect always overrides the sequential fetch_pc update made earlier in this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (granted) begin
                        state    <= WAIT;
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 64'd4;
                        drop     <= redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                        drop  <= 1'b0;
                    end else if (redirect) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end
        end
    end

`ifdef YSYX_22041071_IFU_PERF_EN
    // Flushed work is the buffered entries lost to a redirect plus every discarded response.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 64'd1;
            end
            perf_flushed <= perf_flushed
                          + (redirect ? 64'(fifo_count) : 64'd0)
                          + 64'(resp_seen && !push);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041071_ifu.sv
// Randomized bench for ysyx_22041071_ifu, checked every cycle against a queue-level fetch model.
`timescale 1ns/1ps
module tb_ysyx_22041071_ifu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_ex;
    logic [63:0] redirect_ex_pc;
    logic        redirect_id;
    logic [63:0] redirect_id_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] PC2;
    logic [31:0] Ins1;
    logic        valid2;
    logic        ready2;

    always #5 clk = ~clk;

    ysyx_22041071_ifu #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_ex    (redirect_ex),
        .redirect_ex_pc (redirect_ex_pc),
        .redirect_id    (redirect_id),
        .redirect_id_pc (redirect_id_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .PC2            (PC2),
        .Ins1           (Ins1),
        .valid2         (valid2),
        .ready2         (ready2)
    );

    int   total = 0;
    int   bad   = 0;
    logic check_en = 1'b0;

    function automatic logic [31:0] ins_of(input logic [63:0] a);
        return a[31:0] ^ {a[17:2], 16'h0013};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: what decode should see, what address should be fetched, whether a request is owed.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      q[$];
    logic [63:0] exp_pc = RESET_PC;
    logic        idle_m = 1'b1;
    logic        m_pend = 1'b0;
    logic        m_drop = 1'b0;
    logic [63:0] m_addr = '0;

    function automatic logic model_req();
        return !idle_m && !m_pend && (q.size() < DEPTH);
    endfunction

    always @(posedge clk) begin
        logic        will_req;
        logic        redir;
        logic [63:0] tgt;
        will_req = model_req();
        redir    = redirect_ex || redirect_id;
        tgt      = (redirect_ex ? redirect_ex_pc : redirect_id_pc) & ~64'h3;
        if (reset) begin
            q.delete();
            exp_pc = RESET_PC;
            idle_m = 1'b1;
            m_pend = 1'b0;
            m_drop = 1'b0;
        end else begin
            if (q.size() > 0 && ready2) void'(q.pop_front());
            if (imem_rvalid && m_pend) begin
                if (!m_drop && !redir) q.push_back({m_addr, ins_of(m_addr)});
                m_pend = 1'b0;
            end else if (redir && m_pend) begin
                m_drop = 1'b1;
            end
            if (imem_gnt && will_req) begin
                m_pend = 1'b1;
                m_drop = redir;
                m_addr = exp_pc;
                exp_pc = exp_pc + 64'd4;
            end
            if (redir) begin
                q.delete();
                exp_pc = tgt;
            end
            idle_m = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("imem_req", 64'(imem_req), 64'(model_req()));
            checkOutput("imem_addr", imem_addr, exp_pc);
            checkOutput("valid2", 64'(valid2), 64'(q.size() > 0));
            if (q.size() > 0) begin
                checkOutput("PC2", PC2, q[0].pc);
                checkOutput("Ins1", 64'(Ins1), 64'(q[0].ins));
            end
        end
    end

    // Memory side: single-slot responder with programmable grant delay and response latency.
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = '0;
    int          gwait    = 0;
    int          g_min = 0, g_max = 0, r_min = 0, r_max = 0, ready_pct = 100;

    task automatic applyStimulus(input logic rst, input logic rex, input logic [63:0] rex_pc,
                                 input logic rid, input logic [63:0] rid_pc);
        @(negedge clk);
        #1;
        reset          = rst;
        redirect_ex    = rex;
        redirect_ex_pc = rex_pc;
        redirect_id    = rid;
        redirect_id_pc = rid_pc;
        ready2         = int'($urandom_range(99, 0)) < ready_pct;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ins_of(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (imem_req) begin
            if (gwait == 0) begin
                imem_gnt = 1'b1;
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = int'($urandom_range(r_max, r_min));
                gwait    = int'($urandom_range(g_max, g_min));
            end else begin
                gwait--;
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    initial begin
        reset = 1'b1; redirect_ex = 1'b0; redirect_ex_pc = '0; redirect_id = 1'b0; redirect_id_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; ready2 = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        checkOutput("reset imem_req", 64'(imem_req), 64'd0);
        checkOutput("reset imem_addr", imem_addr, 64'h8000_0000);
        checkOutput("reset valid2", 64'(valid2), 64'd0);
        checkOutput("reset PC2", PC2, 64'd0);
        checkOutput("reset Ins1", 64'(Ins1), 64'd0);
        check_en = 1'b1;

        // Zero-wait memory, decode always ready.
        idleCycle();
        idleCycle();
        checkOutput("first req", 64'(imem_req), 64'd1);
        checkOutput("first addr", imem_addr, 64'h8000_0000);
        idleCycle();
        idleCycle();
        checkOutput("first valid2", 64'(valid2), 64'd1);
        checkOutput("first PC2", PC2, 64'h8000_0000);
        checkOutput("first Ins1", 64'(Ins1), 64'h8000_0013);
        checkOutput("second addr", imem_addr, 64'h8000_0004);
        idleCycle();
        idleCycle();
        checkOutput("second PC2", PC2, 64'h8000_0004);
        checkOutput("second Ins1", 64'(Ins1), 64'h8001_0017);
        repeat (20) idleCycle();

        // Decode stalled: buffer fills and fetching stops.
        ready_pct = 0;
        repeat (10) idleCycle();
        checkOutput("stall model depth", 64'(q.size()), 64'd2);
        checkOutput("stall valid2", 64'(valid2), 64'd1);
        checkOutput("stall imem_req", 64'(imem_req), 64'd0);
        ready_pct = 100;
        repeat (20) idleCycle();

        // Execute redirect while a response is outstanding.
        r_min = 3; r_max = 3;
        for (int i = 0; i < 20 && !(m_pend && mem_busy && mem_cnt > 0); i++) idleCycle();
        checkOutput("reach wait", 64'(m_pend && mem_busy && mem_cnt > 0), 64'd1);
        applyStimulus(1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
        r_min = 0; r_max = 0;
        idleCycle();
        checkOutput("redirect valid2 low", 64'(valid2), 64'd0);
        for (int i = 0; i < 30 && !valid2; i++) idleCycle();
        checkOutput("redirect valid2", 64'(valid2), 64'd1);
        checkOutput("redirect PC2", PC2, 64'h8000_0100);
        repeat (10) idleCycle();

        // Simultaneous redirects: execute wins.
        applyStimulus(1'b0, 1'b1, 64'h200, 1'b1, 64'h300);
        idleCycle();
        checkOutput("priority addr", imem_addr, 64'h200);
        repeat (10) idleCycle();

        // Slow grant.
        g_min = 3; g_max = 3; gwait = 3;
        repeat (30) idleCycle();
        g_min = 0; g_max = 0; gwait = 0;

        // Reset in the middle of an outstanding fetch, stale response afterwards.
        r_min = 4; r_max = 4;
        for (int i = 0; i < 20 && !(m_pend && mem_busy && mem_cnt > 0); i++) idleCycle();
        checkOutput("reach wait2", 64'(m_pend && mem_busy && mem_cnt > 0), 64'd1);
        r_min = 0; r_max = 0;
        repeat (2) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        idleCycle();
        idleCycle();
        checkOutput("post reset req", 64'(imem_req), 64'd1);
        checkOutput("post reset addr", imem_addr, 64'h8000_0000);
        repeat (10) idleCycle();

        // Random traffic with redirects and occasional resets.
        g_min = 0; g_max = 2; r_min = 0; r_max = 2; ready_pct = 70;
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(199, 0) == 0,
                          $urandom_range(11, 0) == 0, {32'h8000_0000, $urandom},
                          $urandom_range(11, 0) == 0, {32'h8000_0000, $urandom});
        end
        ready_pct = 100; g_max = 0; r_max = 0;
        repeat (10) idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
